// File: rtl/wb_slave_watchdog.sv
// wb_slave_watchdog: bus-timeout guard for one Wishbone slave port.
// Passes pipelined traffic through with zero latency, tracks outstanding
// requests, and aborts a peripheral that stalls or stops acknowledging.
// When the optional macro WB_WDOG_STATUS_EN is defined, two status outputs
// are added: o_timeouts (abort count) and o_last_addr (address of the last
// accepted strobe at abort time).
module wb_slave_watchdog #(
    parameter int unsigned AW      = 30,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned LGOUT   = 4
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    // crossbar side
    input  logic            i_scyc,
    input  logic            i_sstb,
    input  logic            i_swe,
    input  logic [AW-1:0]   i_saddr,
    input  logic [DW-1:0]   i_sdata,
    input  logic [DW/8-1:0] i_ssel,
    output logic            o_sstall,
    output logic            o_sack,
    output logic            o_serr,
    output logic [DW-1:0]   o_sdata,
`ifdef WB_WDOG_STATUS_EN
    output logic [7:0]      o_timeouts,
    output logic [AW-1:0]   o_last_addr,
`endif
    // peripheral side
    output logic            o_pcyc,
    output logic            o_pstb,
    output logic            o_pwe,
    output logic [AW-1:0]   o_paddr,
    output logic [DW-1:0]   o_pdata,
    output logic [DW/8-1:0] o_psel,
    input  logic            i_pstall,
    input  logic            i_pack,
    input  logic            i_perr,
    input  logic [DW-1:0]   i_pdata
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [LGOUT-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0]    TMO_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0]    TMO_EXP = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ABORT  = 2'd2,   // first abort cycle: error pulse to the crossbar
        S_HOLD   = 2'd3    // abort held until the master drops cyc
    } state_t;

    state_t            state_q, state_d;
    logic [LGOUT-1:0]  count_q, count_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic abort;
    logic timeout_err;
    logic full;
    logic accept;
    logic ack;
    logic perr;
    logic tclr;
    logic tinc;
    logic expire;

    // Status flags derived from the registered state
    always_comb begin
        abort       = (state_q == S_ABORT) || (state_q == S_HOLD);
        timeout_err = (state_q == S_ABORT);
        full        = (count_q == CNT_MAX);
    end

    // Zero-latency request/response paths; input-driven terms are gated by
    // reset so every output reads its reset value while reset is asserted
    always_comb begin
        o_pcyc   = i_reset_n & i_scyc & ~abort;
        o_pstb   = o_pcyc & i_sstb & ~full;
        o_pwe    = i_swe;
        o_paddr  = i_saddr;
        o_pdata  = i_sdata;
        o_psel   = i_ssel;
        o_sack   = i_pack & o_pcyc;
        o_serr   = (i_perr & o_pcyc) | timeout_err;
        o_sdata  = i_pdata;
        o_sstall = i_reset_n & (i_pstall | full | abort);
    end

    // Per-cycle bus events feeding the counter, timer and FSM
    always_comb begin
        accept = o_pstb & ~i_pstall;
        ack    = o_sack;
        perr   = i_perr & o_pcyc;
        tclr   = accept | ack | perr;
        tinc   = (count_q != '0) | (i_sstb & i_pstall);
        // Timer is about to reach TIMEOUT with no sign of life this cycle;
        // any ack/accept/error this cycle clears it instead
        expire = ~tclr & tinc & (timer_q == TMO_EXP);
    end

    // Next state, outstanding count and idle timer
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE, S_ACTIVE: begin
                if (!i_scyc) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    timer_d = '0;
                end else begin
                    state_d = expire ? S_ABORT : S_ACTIVE;
                    if (perr) begin
                        count_d = '0;
                    end else if (accept && !(ack && count_q != '0)) begin
                        count_d = count_q + LGOUT'(1);
                    end else if (!accept && ack && count_q != '0) begin
                        count_d = count_q - LGOUT'(1);
                    end
                    if (tclr) begin
                        timer_d = '0;
                    end else if (tinc && timer_q != TMO_MAX) begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_ABORT, S_HOLD: begin
                count_d = '0;
                timer_d = '0;
                state_d = i_scyc ? S_HOLD : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
                timer_d = '0;
            end
        endcase
    end

    // State, counter and timer registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

`ifdef WB_WDOG_STATUS_EN
    logic [AW-1:0] acc_addr_q;
    logic [7:0]    timeouts_q;
    logic [AW-1:0] last_addr_q;

    // Abort statistics: saturating abort count and address snapshot
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_addr_q  <= '0;
            timeouts_q  <= '0;
            last_addr_q <= '0;
        end else begin
            if (accept) begin
                acc_addr_q <= i_saddr;
            end
            if (expire && (state_q == S_IDLE || state_q == S_ACTIVE) && i_scyc) begin
                if (timeouts_q != 8'hFF) begin
                    timeouts_q <= timeouts_q + 8'd1;
                end
                last_addr_q <= acc_addr_q;
            end
        end
    end

    always_comb begin
        o_timeouts  = timeouts_q;
        o_last_addr = last_addr_q;
    end
`else
    // status registers absent in this build
`endif

endmodule

// File: tb/tb_wb_slave_watchdog.sv
// Testbench for wb_slave_watchdog: directed scenarios plus randomized
// traffic, checked every cycle against a behavioural model.
module tb_wb_slave_watchdog;

    localparam int AW     = 30;
    localparam int DW     = 32;
    localparam int TMO    = 16;
    localparam int LGOUT  = 4;
    localparam int MAXOUT = (1 << LGOUT) - 1;

    logic            clk = 1'b0;
    logic            i_reset_n;
    logic            i_scyc, i_sstb, i_swe;
    logic [AW-1:0]   i_saddr;
    logic [DW-1:0]   i_sdata;
    logic [DW/8-1:0] i_ssel;
    logic            o_sstall, o_sack, o_serr;
    logic [DW-1:0]   o_sdata;
    logic            o_pcyc, o_pstb, o_pwe;
    logic [AW-1:0]   o_paddr;
    logic [DW-1:0]   o_pdata;
    logic [DW/8-1:0] o_psel;
    logic            i_pstall, i_pack, i_perr;
    logic [DW-1:0]   i_pdata;
`ifdef WB_WDOG_STATUS_EN
    logic [7:0]      o_timeouts;
    logic [AW-1:0]   o_last_addr;
`endif

    always #5 clk = ~clk;

    wb_slave_watchdog #(.AW(AW), .DW(DW), .TIMEOUT(TMO), .LGOUT(LGOUT)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
        .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
        .o_sstall(o_sstall), .o_sack(o_sack), .o_serr(o_serr), .o_sdata(o_sdata),
`ifdef WB_WDOG_STATUS_EN
        .o_timeouts(o_timeouts), .o_last_addr(o_last_addr),
`endif
        .o_pcyc(o_pcyc), .o_pstb(o_pstb), .o_pwe(o_pwe),
        .o_paddr(o_paddr), .o_pdata(o_pdata), .o_psel(o_psel),
        .i_pstall(i_pstall), .i_pack(i_pack), .i_perr(i_perr), .i_pdata(i_pdata)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = running, 1 = first abort cycle, 2 = abort held
    int            m_mode;
    int            m_cnt;
    int            m_idle;
    int            m_tmo;
    logic [AW-1:0] m_acc_addr;
    logic [AW-1:0] m_last_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_idle = 0; m_tmo = 0;
        m_acc_addr = '0; m_last_addr = '0;
    endtask

    // Compare every output with the model for the current inputs, then advance it
    task automatic model_cycle();
        bit ab, full, e_pcyc, e_pstb, e_sack, e_serr, e_sstall, acc;
        int old;
        ab       = (m_mode != 0);
        full     = (m_cnt == MAXOUT);
        e_pcyc   = i_scyc && !ab;
        e_pstb   = e_pcyc && i_sstb && !full;
        e_sack   = i_pack && e_pcyc;
        e_serr   = (i_perr && e_pcyc) || (m_mode == 1);
        e_sstall = i_pstall || full || ab;
        chk("pcyc",   64'(o_pcyc),   64'(e_pcyc));
        chk("pstb",   64'(o_pstb),   64'(e_pstb));
        chk("sack",   64'(o_sack),   64'(e_sack));
        chk("serr",   64'(o_serr),   64'(e_serr));
        chk("sstall", 64'(o_sstall), 64'(e_sstall));
        chk("sdata",  64'(o_sdata),  64'(i_pdata));
        chk("paddr",  64'(o_paddr),  64'(i_saddr));
        chk("pdata",  64'(o_pdata),  64'(i_sdata));
        chk("psel",   64'(o_psel),   64'(i_ssel));
        chk("pwe",    64'(o_pwe),    64'(i_swe));
`ifdef WB_WDOG_STATUS_EN
        chk("timeouts",  64'(o_timeouts),  64'(m_tmo));
        chk("last_addr", 64'(o_last_addr), 64'(m_last_addr));
`endif
        if (ab) begin
            m_cnt = 0; m_idle = 0;
            m_mode = i_scyc ? 2 : 0;
        end else if (!i_scyc) begin
            m_cnt = 0; m_idle = 0;
        end else begin
            acc = e_pstb && !i_pstall;
            old = m_cnt;
            if (acc) m_acc_addr = i_saddr;
            if (i_perr) m_cnt = 0;
            else m_cnt = old + int'(acc) - int'(e_sack && old > 0);
            if (acc || e_sack || i_perr) begin
                m_idle = 0;
            end else if (old != 0 || (i_sstb && i_pstall)) begin
                if (m_idle + 1 >= TMO) begin
                    m_mode = 1;
                    m_idle = 0;
                    if (m_tmo < 255) m_tmo++;
                    m_last_addr = m_acc_addr;
                end else begin
                    m_idle++;
                end
            end
        end
    endtask

    // Drive one cycle of inputs after the edge, check at the falling edge
    task automatic step(input bit cyc, input bit stb, input bit pst, input bit pk, input bit pe,
                        input logic [AW-1:0] a = '0, input logic [DW-1:0] pd = '0);
        @(posedge clk);
        #1;
        i_scyc = cyc; i_sstb = stb; i_pstall = pst; i_pack = pk; i_perr = pe;
        i_saddr = a; i_pdata = pd;
        i_swe = 1'($urandom); i_sdata = $urandom; i_ssel = 4'($urandom);
        @(negedge clk);
        model_cycle();
    endtask

    task automatic clear_inputs();
        i_scyc = 0; i_sstb = 0; i_swe = 0; i_saddr = '0; i_sdata = '0; i_ssel = '0;
        i_pstall = 0; i_pack = 0; i_perr = 0; i_pdata = '0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    initial begin
        int drop;
        int phase_len;
        bit silent;
        bit st;

        // Reset state
        i_reset_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        chk("rst_pcyc",   64'(o_pcyc),   64'd0);
        chk("rst_pstb",   64'(o_pstb),   64'd0);
        chk("rst_sstall", 64'(o_sstall), 64'd0);
        chk("rst_sack",   64'(o_sack),   64'd0);
        chk("rst_serr",   64'(o_serr),   64'd0);
        repeat (2) @(posedge clk);
        release_reset();

        // Single read, acked three cycles after acceptance
        step(1, 1, 0, 0, 0, 30'h100);
        chk("rd_pstb",  64'(o_pstb),  64'd1);
        chk("rd_paddr", 64'(o_paddr), 64'h100);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, '0, 32'hDEADBEEF);
        chk("rd_sack",  64'(o_sack),  64'd1);
        chk("rd_sdata", 64'(o_sdata), 64'hDEADBEEF);
        chk("rd_serr",  64'(o_serr),  64'd0);
        step(0, 0, 0, 0, 0);

        // Burst filling the outstanding counter
        for (int i = 0; i < MAXOUT; i++) step(1, 1, 0, 0, 0, 30'(i));
        step(1, 1, 0, 0, 0, 30'h55);
        chk("full_stall", 64'(o_sstall), 64'd1);
        chk("full_pstb",  64'(o_pstb),   64'd0);
        step(1, 1, 0, 1, 0, 30'h55);
        chk("full_ack_stall", 64'(o_sstall), 64'd1);
        for (int i = 0; i < MAXOUT - 1; i++) begin
            step(1, 0, 0, 1, 0);
            chk("burst_ack", 64'(o_sack), 64'd1);
        end
        step(0, 0, 0, 0, 0);

        // Silent peripheral: error pulse exactly 17 cycles after acceptance
        step(1, 1, 0, 0, 0, 30'h2A);
        for (int k = 1; k <= TMO; k++) begin
            step(1, 0, 0, 0, 0);
            chk("silent_no_err", 64'(o_serr), 64'd0);
        end
        step(1, 0, 0, 0, 0);
        chk("silent_err",  64'(o_serr), 64'd1);
        chk("silent_pcyc", 64'(o_pcyc), 64'd0);
        step(1, 0, 0, 1, 0);
        chk("hold_serr",   64'(o_serr),   64'd0);
        chk("hold_sack",   64'(o_sack),   64'd0);
        chk("hold_sstall", 64'(o_sstall), 64'd1);
`ifdef WB_WDOG_STATUS_EN
        chk("tmo_count", 64'(o_timeouts),  64'd1);
        chk("tmo_addr",  64'(o_last_addr), 64'h2A);
`endif
        // Reset asserted mid-abort
        step(1, 1, 1, 0, 0);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_pcyc",   64'(o_pcyc),   64'd0);
        chk("mid_rst_sstall", 64'(o_sstall), 64'd0);
        chk("mid_rst_serr",   64'(o_serr),   64'd0);
`ifdef WB_WDOG_STATUS_EN
        chk("mid_rst_tmo",    64'(o_timeouts), 64'd0);
`endif
        model_reset();
        clear_inputs();
        repeat (2) @(posedge clk);
        release_reset();

        // Stalled strobe: same abort timing, late ack dropped
        for (int k = 0; k < TMO; k++) step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("stall_err", 64'(o_serr), 64'd1);
        step(1, 0, 0, 1, 0);
        chk("stall_late_ack", 64'(o_sack), 64'd0);
        step(0, 0, 0, 0, 0);

        // Error on the second of four outstanding requests
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 30'(i));
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1);
        chk("perr_serr", 64'(o_serr), 64'd1);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 30'h77);
        chk("after_perr_pstb",   64'(o_pstb),   64'd1);
        chk("after_perr_sstall", 64'(o_sstall), 64'd0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Randomized traffic with silent phases to provoke timeouts
        drop = 0; phase_len = 0; silent = 0; st = 0;
        for (int c = 0; c < 4000; c++) begin
            if (phase_len == 0) begin
                phase_len = $urandom_range(60, 20);
                silent = ($urandom_range(9, 0) < 3);
                st = 1'($urandom);
            end
            phase_len--;
            if (drop > 0) drop--;
            else if ($urandom_range(99, 0) < 3) drop = $urandom_range(3, 1);
            if (silent)
                step(drop == 0, ($urandom_range(9, 0) < 4), st, 0, 0, 30'($urandom), $urandom);
            else
                step(drop == 0, ($urandom_range(9, 0) < 6), ($urandom_range(9, 0) < 3),
                     ($urandom_range(9, 0) < 4), ($urandom_range(99, 0) < 3),
                     30'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
